// File: rtl/cover_arb_pkg.sv
// cover_arb_pkg: shared FSM type, index width default and saturating adder for the coverage arbiter.
package cover_arb_pkg;
    localparam int IDX_W_DEF = 64;
    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;
    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction
endpackage

// File: rtl/cover_rr_pick.sv
// cover_rr_pick: round-robin find-first over requester groups, then lowest set bit inside the chosen group.
module cover_rr_pick
    import cover_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int REQ_W = 8,
    localparam int NB = NUM_REQ * REQ_W,
    localparam int GW = $clog2(NUM_REQ),
    localparam int BW = (REQ_W > 1) ? $clog2(REQ_W) : 1
) (
    input  logic [NB-1:0] pend_i,
    input  logic [GW-1:0] rr_ptr_i,
    output logic          valid_o,
    output logic [GW-1:0] grp_o,
    output logic [BW-1:0] bit_o,
    output logic [NB-1:0] mask_o
);
    always_comb begin
        int g;
        logic [REQ_W-1:0] sl;
        valid_o = 1'b0;
        grp_o = '0;
        bit_o = '0;
        mask_o = '0;
        sl = '0;
        g = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            g = int'(rr_ptr_i) + k;
            if (g >= NUM_REQ) g = g - NUM_REQ;
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!valid_o && j == g && |pend_i[j*REQ_W +: REQ_W]) begin
                    valid_o = 1'b1;
                    grp_o = GW'(j);
                    sl = pend_i[j*REQ_W +: REQ_W];
                end
            end
        end
        for (int b = REQ_W - 1; b >= 0; b--) if (sl[b]) bit_o = BW'(b);
        for (int i = 0; i < NB; i++) mask_o[i] = valid_o && (i == int'(grp_o) * REQ_W + int'(bit_o));
    end
endmodule

// File: rtl/cover_toggle_arbiter.sv
// cover_toggle_arbiter: merges sticky toggle-coverage hits and serializes them as cover indices with flush/drain.
// Optional COVER_FIRST_HIT_EN: each index is reported at most once until reset.
module cover_toggle_arbiter
    import cover_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int REQ_W = 8,
    parameter int COVER_INDEX = 0,
    parameter int COVER_TOTAL = 8744,
    parameter int IDX_W = IDX_W_DEF,
    localparam int NB = NUM_REQ * REQ_W,
    localparam int CW = $clog2(NB + 1),
    localparam int GW = $clog2(NUM_REQ),
    localparam int BW = (REQ_W > 1) ? $clog2(REQ_W) : 1
) (
    input  logic             gbl_clk,
    input  logic             reset,
    input  logic [NB-1:0]    hit_valid,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_index,
    input  logic             flush_req,
    output logic             flush_done,
    output logic [CW-1:0]    pending_cnt,
    output logic [31:0]      merge_cnt
);
    generate
        if (COVER_INDEX + NB > COVER_TOTAL) begin : g_range_err
            $error("cover_toggle_arbiter: COVER_INDEX + NUM_REQ*REQ_W exceeds COVER_TOTAL");
        end
    endgenerate

    state_t           state_q, state_d;
    logic [NB-1:0]    pend_q, pend_d, hit_acc, load_mask, merge_bits, pick_mask;
    logic             out_valid_q, out_valid_d, pick_valid, load, fire;
    logic [IDX_W-1:0] out_index_q, out_index_d;
    logic [GW-1:0]    rr_q, rr_d, pick_grp;
    logic [BW-1:0]    pick_bit;
    logic [CW-1:0]    pcnt_q;
    logic [31:0]      merge_q, merge_d;
`ifdef COVER_FIRST_HIT_EN
    logic [NB-1:0]    seen_q;
`endif

    cover_rr_pick #(.NUM_REQ(NUM_REQ), .REQ_W(REQ_W)) u_pick (
        .pend_i   (pend_q),
        .rr_ptr_i (rr_q),
        .valid_o  (pick_valid),
        .grp_o    (pick_grp),
        .bit_o    (pick_bit),
        .mask_o   (pick_mask)
    );

    always_comb begin
        fire = out_valid_q && out_ready;
        load = pick_valid && (!out_valid_q || out_ready);
        load_mask = load ? pick_mask : '0;
`ifdef COVER_FIRST_HIT_EN
        // The index being loaded counts as seen already, so a same-cycle repeat is not re-queued.
        hit_acc = (state_q == RUN) ? (hit_valid & ~(seen_q | load_mask)) : '0;
`else
        hit_acc = (state_q == RUN) ? hit_valid : '0;
`endif
        merge_bits = hit_acc & pend_q & ~load_mask;
        pend_d = (pend_q & ~load_mask) | hit_acc;
        merge_d = sat_add32(merge_q, 32'($countones(merge_bits)));
        rr_d = load ? ((int'(pick_grp) == NUM_REQ - 1) ? '0 : pick_grp + 1'b1) : rr_q;
        out_valid_d = load || (out_valid_q && !fire);
        out_index_d = load ? IDX_W'(COVER_INDEX + int'(pick_grp) * REQ_W + int'(pick_bit)) : out_index_q;
        state_d = (state_q == RUN)   ? (flush_req ? DRAIN : RUN) :
                  (state_q == DRAIN) ? (!flush_req ? RUN : (!pick_valid && !out_valid_q) ? DONE : DRAIN) :
                                       (flush_req ? DONE : RUN);
    end

    always_ff @(posedge gbl_clk) begin
        if (!reset) begin
            state_q <= RUN;
            pend_q <= '0;
            out_valid_q <= 1'b0;
            out_index_q <= '0;
            rr_q <= '0;
            pcnt_q <= '0;
            merge_q <= '0;
`ifdef COVER_FIRST_HIT_EN
            seen_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            pend_q <= pend_d;
            out_valid_q <= out_valid_d;
            out_index_q <= out_index_d;
            rr_q <= rr_d;
            pcnt_q <= CW'($countones(pend_d));
            merge_q <= merge_d;
`ifdef COVER_FIRST_HIT_EN
            seen_q <= seen_q | load_mask;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_index = out_index_q;
    assign flush_done = (state_q == DONE);
    assign pending_cnt = pcnt_q;
    assign merge_cnt = merge_q;
endmodule

// File: tb/tb_cover_toggle_arbiter.sv
// tb_cover_toggle_arbiter: vector table, directed corner sequences and random traffic against a reference model.
module tb_cover_toggle_arbiter;
    localparam int NR = 4;
    localparam int RW = 8;
    localparam int NB = NR * RW;
`ifdef COVER_FIRST_HIT_EN
    localparam bit FH = 1'b1;
`else
    localparam bit FH = 1'b0;
`endif

    logic          gbl_clk = 1'b0;
    logic          reset = 1'b0;
    logic [NB-1:0] hit_valid = '0;
    logic          out_ready = 1'b0;
    logic          flush_req = 1'b0;
    logic          out_valid, flush_done;
    logic [63:0]   out_index;
    logic [5:0]    pending_cnt;
    logic [31:0]   merge_cnt;

    always #5 gbl_clk = ~gbl_clk;

    cover_toggle_arbiter #(.NUM_REQ(NR), .REQ_W(RW), .COVER_INDEX(0), .COVER_TOTAL(8744), .IDX_W(64)) dut (
        .gbl_clk     (gbl_clk),
        .reset       (reset),
        .hit_valid   (hit_valid),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_index   (out_index),
        .flush_req   (flush_req),
        .flush_done  (flush_done),
        .pending_cnt (pending_cnt),
        .merge_cnt   (merge_cnt)
    );

    // Reference state: pending set, already-reported set, fairness pointer, output slot, mode (0 run, 1 drain, 2 done).
    bit              m_pend[NB];
    bit              m_seen[NB];
    int              m_rr, m_st;
    bit              m_ov;
    longint          m_idx;
    longint unsigned m_mc;
    int              n_cmp = 0, n_bad = 0;

    task automatic check(input string nm, input longint unsigned act, input longint unsigned exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    function automatic int pend_count();
        int c = 0;
        for (int i = 0; i < NB; i++) c += int'(m_pend[i]);
        return c;
    endfunction

    task automatic model_step();
        int ld = -1;
        int merges = 0;
        int empty;
        bit acc[NB];
        if (!reset) begin
            for (int i = 0; i < NB; i++) begin m_pend[i] = 0; m_seen[i] = 0; end
            m_rr = 0; m_st = 0; m_ov = 0; m_idx = 0; m_mc = 0;
            return;
        end
        empty = (pend_count() == 0);
        if (!m_ov || out_ready)
            for (int k = 0; k < NR && ld < 0; k++) begin
                int g = (m_rr + k) % NR;
                for (int b = 0; b < RW && ld < 0; b++) if (m_pend[g*RW + b]) ld = g*RW + b;
            end
        for (int i = 0; i < NB; i++) begin
            acc[i] = (m_st == 0) && hit_valid[i];
            if (FH) acc[i] = acc[i] && !m_seen[i] && i != ld;
            if (acc[i] && m_pend[i] && i != ld) merges++;
        end
        case (m_st)
            0: m_st = flush_req ? 1 : 0;
            1: m_st = !flush_req ? 0 : (empty && !m_ov) ? 2 : 1;
            default: m_st = flush_req ? 2 : 0;
        endcase
        if (ld >= 0) begin
            m_pend[ld] = 0;
            m_seen[ld] = 1;
            m_ov = 1;
            m_idx = ld;
            m_rr = (ld / RW + 1) % NR;
        end else if (m_ov && out_ready) m_ov = 0;
        for (int i = 0; i < NB; i++) if (acc[i]) m_pend[i] = 1;
        m_mc = (m_mc + merges > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_mc + merges;
    endtask

    task automatic cyc();
        model_step();
        @(posedge gbl_clk);
        #1;
        check("model out_valid", out_valid, m_ov);
        check("model out_index", out_index, m_idx);
        check("model pending_cnt", pending_cnt, pend_count());
        check("model merge_cnt", merge_cnt, m_mc);
        check("model flush_done", flush_done, m_st == 2);
    endtask

    task automatic drive(input logic [NB-1:0] h, input bit r, input bit f);
        hit_valid = h; out_ready = r; flush_req = f; reset = 1'b1;
    endtask

    task automatic do_reset();
        hit_valid = '0; flush_req = 0; reset = 0;
        cyc();
        reset = 1;
    endtask

    typedef struct {
        logic [NB-1:0] hit;
        bit            rdy;
        bit            rst_n;
        bit            ev;
        longint        ei;
        int            ep;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic [NB-1:0] h, input bit r, input bit n, input bit v, input longint i, input int p);
        vec_t t;
        t.hit = h; t.rdy = r; t.rst_n = n; t.ev = v; t.ei = i; t.ep = p;
        tbl.push_back(t);
    endtask

    initial begin
        bit done_seen, saw31;
        // reset, single hit on bit 10, fresh reset, then round-robin over four groups and within group 0
        add('0, 1, 0, 0, 0, 0);
        add('0, 1, 0, 0, 0, 0);
        add('0, 1, 0, 0, 0, 0);
        add(32'h0000_0400, 1, 1, 0, 0, 1);
        add('0, 1, 1, 1, 10, 0);
        add('0, 1, 1, 0, 10, 0);
        add('0, 1, 0, 0, 0, 0);
        add(32'h0202_0201, 1, 1, 0, 0, 4);
        add('0, 1, 1, 1, 0, 3);
        add('0, 1, 1, 1, 9, 2);
        add('0, 1, 1, 1, 17, 1);
        add('0, 1, 1, 1, 25, 0);
        add('0, 1, 1, 0, 25, 0);
        add(32'h0000_000A, 1, 1, 0, 25, 2);
        add('0, 1, 1, 1, 1, 1);
        add('0, 1, 1, 1, 3, 0);
        add('0, 1, 1, 0, 3, 0);
        foreach (tbl[n]) begin
            hit_valid = tbl[n].hit; out_ready = tbl[n].rdy; reset = tbl[n].rst_n; flush_req = 0;
            cyc();
            check("tbl out_valid", out_valid, tbl[n].ev);
            check("tbl out_index", out_index, tbl[n].ei);
            check("tbl pending_cnt", pending_cnt, tbl[n].ep);
        end

        // backpressure: index 5 held while stalled, a re-hit mid-stall is new (not a merge)
        do_reset();
        drive(32'h20, 0, 0); cyc();
        check("bp pending", pending_cnt, 1);
        drive('0, 0, 0); cyc();
        check("bp first valid", out_valid, 1);
        for (int s = 0; s < 6; s++) begin
            drive((s == 2) ? 32'h20 : 32'h0, 0, 0); cyc();
            check("bp hold index", out_index, 5);
            check("bp hold valid", out_valid, 1);
        end
        drive('0, 1, 0); cyc();
        check("bp re-report", out_valid, !FH);
        check("bp no merge", merge_cnt, 0);
        cyc();
        check("bp drained", out_valid, 0);

        // merge: bit 6 stalled in output, bit 7 hit four times -> three merges, single report
        do_reset();
        drive(32'h40, 0, 0); cyc();
        drive('0, 0, 0); cyc();
        check("mg hold 6", out_index, 6);
        for (int s = 0; s < 4; s++) begin drive(32'h80, 0, 0); cyc(); end
        check("mg count", merge_cnt, 3);
        check("mg pending", pending_cnt, 1);
        drive('0, 1, 0); cyc();
        check("mg report 7", out_index, 7);
        check("mg report valid", out_valid, 1);
        cyc();
        check("mg single report", out_valid, 0);

        // flush: drain pending, ignore hits in DRAIN, then release to RUN
        do_reset();
        drive(32'h0010_1004, 1, 0); cyc();
        drive('0, 1, 1); cyc();
        done_seen = 0; saw31 = 0;
        for (int s = 0; s < 20 && !done_seen; s++) begin
            drive(32'h8000_0000, 1, 1); cyc();
            if (out_valid && out_index == 31) saw31 = 1;
            done_seen = flush_done;
        end
        check("fl done within bound", done_seen, 1);
        check("fl ignored hit", saw31, 0);
        check("fl empty", pending_cnt, 0);
        check("fl out idle", out_valid, 0);
        drive('0, 1, 0); cyc();
        check("fl back to run", flush_done, 0);

        // reset mid-drain discards pending, merges, pointer
        do_reset();
        drive(32'h0307_0000, 0, 0); cyc();
        drive(32'h0002_0000, 0, 1); cyc();
        check("rd merged before reset", merge_cnt, 1);
        hit_valid = '0; flush_req = 0; reset = 0; cyc();
        check("rd out_valid", out_valid, 0);
        check("rd pending", pending_cnt, 0);
        check("rd merge", merge_cnt, 0);
        check("rd flush_done", flush_done, 0);
        drive(32'h0200_0002, 1, 0); cyc();
        drive('0, 1, 0); cyc();
        check("rd pointer reset", out_index, 1);
        cyc();

        if (FH) begin
            do_reset();
            drive(32'h8, 1, 0); cyc();
            drive('0, 1, 0); cyc();
            check("fh first report", out_index, 3);
            cyc();
            drive(32'h8, 1, 0); cyc();
            drive('0, 1, 0); cyc();
            check("fh no repeat", out_valid, 0);
            check("fh no pending", pending_cnt, 0);
        end

        // random traffic against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            hit_valid = $urandom & $urandom & $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 49) == 0) flush_req = ~flush_req;
            reset = ($urandom_range(0, 199) != 0);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
